// File: rtl/meter_pkg.sv
// Shared types and helpers for the frequency/duty-cycle meter channel scheduler.
package meter_pkg;

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned CH_MAX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    GATE,
    LATCH,
    OUTPUT
  } state_e;

  typedef struct packed {
    logic [CH_MAX_W-1:0] ch;
    logic [CNT_W-1:0]    high;
    logic [CNT_W-1:0]    low;
    logic [CNT_W-1:0]    edges;
  } result_t;

  // Round-robin: first set mask bit strictly after last_ch, wrapping; unused upper mask bits must be 0.
  function automatic logic [CH_MAX_W-1:0] next_ch(input logic [15:0]         mask,
                                                  input logic [CH_MAX_W-1:0] last_ch);
    logic                found;
    logic [CH_MAX_W-1:0] idx;
    next_ch = last_ch;
    found   = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = last_ch + CH_MAX_W'(i);
      if (!found && mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/meter_sync.sv
// Two-flop synchronizer over a vector of independent asynchronous bits.
module meter_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/meter_channel_scheduler.sv
// Round-robin scheduler sharing one gated high/low/edge counter across N_CH meter inputs.
module meter_channel_scheduler #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CNT_W         = meter_pkg::CNT_W,
  parameter int unsigned GATE_CYCLES   = 100_000_000,
  parameter int unsigned SETTLE_CYCLES = 10
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [N_CH-1:0]         ch_enable,
  input  logic [N_CH-1:0]         sig_in,
  input  logic                    res_ready,
  output logic                    res_valid,
  output logic [$clog2(N_CH)-1:0] res_ch,
  output logic [CNT_W-1:0]        res_high,
  output logic [CNT_W-1:0]        res_low,
  output logic [CNT_W-1:0]        res_edges,
  output logic                    busy
);

  import meter_pkg::*;

  localparam int unsigned CH_W = $clog2(N_CH);

  if (N_CH < 2 || N_CH > 16) begin : g_bad_n_ch
    $error("N_CH must be in 2..16");
  end
  if (GATE_CYCLES < 1 || (CNT_W < 32 && GATE_CYCLES >= (32'd1 << CNT_W))) begin : g_bad_gate
    $error("GATE_CYCLES must be in 1..2**CNT_W-1");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3");
  end

  state_e           state_q, state_d;
  logic [N_CH-1:0]  sync_q;
  logic [CH_W-1:0]  cur_ch, last_ch;
  logic             prev;
  logic             samp_c;
  logic             timer_zero_c;
  logic [CNT_W-1:0] timer, cnt_high, cnt_low, cnt_edges;

  meter_sync #(.W(N_CH)) u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (sync_q)
  );

  assign samp_c       = sync_q[cur_ch];
  assign timer_zero_c = (timer == '0);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run && |ch_enable) state_d = SELECT;
      SELECT:  state_d = (|ch_enable) ? SETTLE : IDLE;
      SETTLE:  if (timer_zero_c) state_d = GATE;
      GATE:    if (timer_zero_c) state_d = LATCH;
      LATCH:   state_d = OUTPUT;
      OUTPUT:  if (res_valid && res_ready) state_d = run ? SELECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers; prev tracks the muxed sample in every state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch    <= '0;
      last_ch   <= CH_W'(N_CH - 1);
      prev      <= 1'b0;
      timer     <= '0;
      cnt_high  <= '0;
      cnt_low   <= '0;
      cnt_edges <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_high  <= '0;
      res_low   <= '0;
      res_edges <= '0;
      busy      <= 1'b0;
    end else begin
      prev      <= samp_c;
      res_valid <= (state_d == OUTPUT);
      busy      <= (state_d != IDLE);
      case (state_q)
        SELECT: begin
          cur_ch    <= CH_W'(next_ch(16'(ch_enable), CH_MAX_W'(last_ch)));
          timer     <= CNT_W'(SETTLE_CYCLES - 1);
          cnt_high  <= '0;
          cnt_low   <= '0;
          cnt_edges <= '0;
        end
        SETTLE: timer <= timer_zero_c ? CNT_W'(GATE_CYCLES - 1) : timer - CNT_W'(1);
        GATE: begin
          if (!timer_zero_c) timer <= timer - CNT_W'(1);
          if (samp_c) cnt_high <= cnt_high + CNT_W'(1);
          else        cnt_low  <= cnt_low + CNT_W'(1);
          if (samp_c && !prev) cnt_edges <= cnt_edges + CNT_W'(1);
        end
        LATCH: begin
          res_ch    <= cur_ch;
          res_high  <= cnt_high;
          res_low   <= cnt_low;
          res_edges <= cnt_edges;
          last_ch   <= cur_ch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_meter_channel_scheduler.sv
// Randomized self-checking bench for meter_channel_scheduler against a duty/period model.
module tb_meter_channel_scheduler;

  import meter_pkg::*;

  localparam int unsigned N_CH = 4;
  localparam int unsigned CW   = 32;
  localparam int unsigned G    = 100;
  localparam int unsigned S    = 4;
  localparam int          LAT_FIRST = int'(S + G + 2);
  localparam int          LAT_NEXT  = int'(S + G + 3);

  logic            sys_clk = 1'b0;
  logic            rst_n, run, res_ready;
  logic [N_CH-1:0] ch_enable;
  logic [N_CH-1:0] sig_in = '0;
  logic            res_valid, busy;
  logic [1:0]      res_ch;
  logic [CW-1:0]   res_high, res_low, res_edges;

  int unsigned cyc = 0;
  int unsigned per [N_CH];
  int unsigned hi  [N_CH];
  int unsigned ph  [N_CH];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          model_last;

  meter_channel_scheduler #(
    .N_CH(N_CH), .CNT_W(CW), .GATE_CYCLES(G), .SETTLE_CYCLES(S)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .run       (run),
    .ch_enable (ch_enable),
    .sig_in    (sig_in),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_high  (res_high),
    .res_low   (res_low),
    .res_edges (res_edges),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Periodic test waveforms, updated away from the sampling edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      for (int c = 0; c < int'(N_CH); c++)
        sig_in[c] = (((cyc + ph[c]) % per[c]) < hi[c]);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Gate spans whole periods, so counts are independent of phase.
  function automatic result_t model_result(input int c);
    result_t r;
    r.ch = 4'(c);
    if (hi[c] == 0) begin
      r.high = 0; r.low = G; r.edges = 0;
    end else if (hi[c] >= per[c]) begin
      r.high = G; r.low = 0; r.edges = 0;
    end else begin
      r.high  = (G / per[c]) * hi[c];
      r.low   = G - r.high;
      r.edges = G / per[c];
    end
    return r;
  endfunction

  // Smallest enabled channel above last, else smallest enabled overall.
  function automatic int model_pick(input logic [N_CH-1:0] mask, input int last);
    int first = -1;
    int after = -1;
    for (int c = int'(N_CH) - 1; c >= 0; c--) begin
      if (mask[c]) begin
        first = c;
        if (c > last) after = c;
      end
    end
    return (after >= 0) ? after : first;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(res_valid), 0);
    check_eq({tag, "_ch"},    64'(res_ch),    0);
    check_eq({tag, "_high"},  64'(res_high),  0);
    check_eq({tag, "_low"},   64'(res_low),   0);
    check_eq({tag, "_edges"}, 64'(res_edges), 0);
    check_eq({tag, "_busy"},  64'(busy),      0);
  endtask

  // Waits for res_valid, checks its latency from t_ref and the result against the model.
  task automatic expect_result(input string tag, input int unsigned t_ref, input int lat,
                               output int unsigned t_valid, output result_t exp);
    bit ok = 1'b0;
    int pick;
    for (int i = 0; i < lat + 20 && !ok; i++) begin
      @(negedge sys_clk);
      if (res_valid) ok = 1'b1;
    end
    t_valid = cyc;
    check_eq({tag, "_valid_seen"}, 64'(ok), 1);
    if (ok) check_eq({tag, "_latency"}, 64'(t_valid - t_ref), 64'(lat));
    pick = model_pick(ch_enable, model_last);
    exp  = model_result(pick);
    check_eq({tag, "_ch"},    64'(res_ch),    64'(exp.ch));
    check_eq({tag, "_high"},  64'(res_high),  64'(exp.high));
    check_eq({tag, "_low"},   64'(res_low),   64'(exp.low));
    check_eq({tag, "_edges"}, 64'(res_edges), 64'(exp.edges));
    model_last = pick;
  endtask

  task automatic drain_to_idle(input string tag);
    repeat (4) @(negedge sys_clk);
    check_eq({tag, "_busy_idle"}, 64'(busy), 0);
  endtask

  initial begin
    int unsigned t0, tv, t_acc;
    int          seen;
    int unsigned plist [3];
    result_t     exp;

    plist[0] = 10; plist[1] = 25; plist[2] = 50;
    per[0] = 20; hi[0] = 5;  ph[0] = $urandom_range(0, 19);
    per[1] = 10; hi[1] = 10; ph[1] = 0;
    per[2] = 10; hi[2] = 0;  ph[2] = 0;
    per[3] = plist[$urandom_range(0, 2)];
    hi[3]  = $urandom_range(1, per[3] - 1);
    ph[3]  = $urandom_range(0, per[3] - 1);

    rst_n = 1'b0; run = 1'b0; res_ready = 1'b1; ch_enable = '0;
    model_last = int'(N_CH) - 1;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Single channel, 25% duty
    @(negedge sys_clk);
    ch_enable = 4'b0001; run = 1'b1; t0 = cyc + 1;
    expect_result("s1", t0, LAT_FIRST, tv, exp);
    run = 1'b0;
    @(negedge sys_clk);
    check_eq("s1_valid_pulse", 64'(res_valid), 0);
    drain_to_idle("s1");

    // Round robin over 1011 from reset, back-to-back
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1; model_last = int'(N_CH) - 1;
    ch_enable = 4'b1011; run = 1'b1; t0 = cyc + 1;
    expect_result("rr0", t0, LAT_FIRST, tv, exp);
    for (int k = 1; k < 5; k++) begin
      t0 = tv;
      expect_result($sformatf("rr%0d", k), t0, LAT_NEXT, tv, exp);
    end
    run = 1'b0;
    drain_to_idle("rr");

    // Back-pressure hold, constant-level channels
    ch_enable = 4'b0110; res_ready = 1'b0; run = 1'b1; t0 = cyc + 1;
    expect_result("hold0", t0, LAT_FIRST, tv, exp);
    repeat (50) begin
      @(negedge sys_clk);
      check_eq("hold_valid", 64'(res_valid), 1);
      check_eq("hold_busy",  64'(busy),      1);
    end
    check_eq("hold_ch",    64'(res_ch),    64'(exp.ch));
    check_eq("hold_high",  64'(res_high),  64'(exp.high));
    check_eq("hold_low",   64'(res_low),   64'(exp.low));
    check_eq("hold_edges", 64'(res_edges), 64'(exp.edges));
    res_ready = 1'b1; t_acc = cyc + 1;
    expect_result("hold1", t_acc, LAT_FIRST, tv, exp);
    run = 1'b0;
    drain_to_idle("hold");

    // run drops during GATE: result still delivered, then idle
    ch_enable = 4'b1000; run = 1'b1; t0 = cyc + 1;
    repeat (50) @(negedge sys_clk);
    run = 1'b0;
    expect_result("rundrop", t0, LAT_FIRST, tv, exp);
    seen = 0;
    repeat (300) begin
      @(negedge sys_clk);
      if (res_valid) seen++;
    end
    check_eq("rundrop_no_more_valid", 64'(seen), 0);
    check_eq("rundrop_busy", 64'(busy), 0);

    // Reset pulse during GATE
    ch_enable = 4'b1010; run = 1'b1;
    repeat (60) @(negedge sys_clk);
    check_eq("rst_mid_busy_before", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge sys_clk);
    rst_n = 1'b1; model_last = int'(N_CH) - 1; t0 = cyc + 1;
    expect_result("rst_after", t0, LAT_FIRST, tv, exp);
    run = 1'b0;
    drain_to_idle("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/meter_channel_scheduler.md
# meter_channel_scheduler

Time-multiplexes one gated high/low/edge counting datapath across `N_CH` asynchronous input signals for the frequency/duty-cycle meter. Round-robins over the enabled channels; each measurement runs a settle window and then a fixed gate window. Each result (channel index, high count, low count, rising-edge count) is handed to a downstream consumer over a valid/ready handshake. Sits between the raw meter inputs and the result formatter or display logic.

## Interface
- `N_CH`, 4: number of input channels, 2..16.
- `CNT_W`, 32: width of the result counters.
- `GATE_CYCLES`, 100_000_000: gate window length in `sys_clk` cycles. Must be < 2^`CNT_W`, enforced by an elaboration check.
- `SETTLE_CYCLES`, 10: discard window after a channel switch, ≥ 3.
- `sys_clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; measurement cycling enabled while high.
- `ch_enable` in `N_CH`: per-channel enable mask.
- `sig_in` in `N_CH`: asynchronous measured signals.
- `res_ready` in 1: consumer ready.
- `res_valid` out 1: result available.
- `res_ch` out `$clog2(N_CH)`: channel of the result.
- `res_high` out `CNT_W`: gate cycles with the signal high.
- `res_low` out `CNT_W`: gate cycles with the signal low.
- `res_edges` out `CNT_W`: rising edges inside the gate.
- `busy` out 1: high in every state except IDLE.

## Operation
- Every `sig_in` bit passes through a 2-flop synchronizer. A mux selects channel `cur_ch`. A previous-sample flop on the mux output gives edge detection.
- **IDLE:** waits for `run`=1 and `|ch_enable`.
  - Leaves to SELECT when both hold.
- **SELECT (1 cycle):** picks the next enabled channel strictly after `last_ch`, wrapping at `N_CH-1`.
  - After reset, `last_ch`=`N_CH-1`, so the first pick is the lowest enabled channel.
  - If only one channel is enabled, it is re-picked every round.
  - If the mask went to zero, returns to IDLE.
  - Clears all three counters.
- **SETTLE (`SETTLE_CYCLES` cycles):** samples are discarded; the previous-sample flop keeps tracking.
- **GATE (`GATE_CYCLES` cycles):** each cycle increments exactly one of `high`/`low`, according to the synchronized level.
  - `edges` increments when the level is 1 and the previous sample is 0. The sample before the first gate cycle counts as "previous".
  - Invariant: `high + low == GATE_CYCLES`.
- **LATCH (1 cycle):** copies the counters and `cur_ch` into the output registers, sets `last_ch` = `cur_ch`, and asserts `res_valid` from the next cycle.
- **OUTPUT:** holds `res_valid` and the data stable until `res_valid && res_ready`.
  - On that edge, `res_valid` drops.
  - Goes to SELECT if `run`=1, else to IDLE.
- `ch_enable` changes take effect only at SELECT. The measurement in progress always completes.
- `run` falling mid-measurement: the current result is still completed and delivered, then the block goes to IDLE.
- Counters never wrap, because of the `GATE_CYCLES` bound.

## Timing
- Reset state: IDLE, `res_valid`=0, `res_ch`=0, `res_high`/`res_low`/`res_edges`=0, `busy`=0, `last_ch`=`N_CH-1`, synchronizers 0.
- Mid-operation `rst_n` assertion forces the reset state immediately; no partial result is ever presented.
- From the clock edge that samples `run`=1 in IDLE to `res_valid` rising: `SETTLE_CYCLES + GATE_CYCLES + 2` cycles.
- Back-to-back with `res_ready` tied high:
  - `res_valid` is high for 1 cycle per result.
  - Results are spaced `SETTLE_CYCLES + GATE_CYCLES + 3` cycles apart.
- Input-to-count latency is 2 cycles (synchronizer). It is absorbed by SETTLE.
- `busy` is registered and reflects the state.

## Structure
- Shared package `meter_pkg`:
  - state enum: IDLE, SELECT, SETTLE, GATE, LATCH, OUTPUT;
  - `CNT_W` default;
  - result struct {ch, high, low, edges}.
- One sub-module, `meter_sync`:
  - parameterized-width 2-flop synchronizer;
  - instantiated once over the full `sig_in` vector.
- The round-robin next-channel function lives in the package. It is a pure function of (`mask`, `last_ch`).

## Test plan
All scenarios use `N_CH`=4, `GATE_CYCLES`=100, `SETTLE_CYCLES`=4.
- ch0 with period 20 (5 high / 15 low), `ch_enable`=4'b0001, `run`=1 → `res_ch`=0, `res_high`=25, `res_low`=75, `res_edges`=5. First `res_valid` 106 cycles after `run` is sampled.
- `ch_enable`=4'b1011, `res_ready`=1, distinct duty per channel → `res_ch` sequence 0,1,3,0,1, each with its matching counts. Results are 107 cycles apart.
- Constant-level channels: ch1 constant 1 → high=100, low=0, edges=0; ch2 constant 0 → high=0, low=100, edges=0.
- `res_ready`=0 for 50 cycles after `res_valid` → valid and data held stable and `busy`=1. The next SETTLE begins the cycle after the accepting edge.
- `run` dropped during GATE → that result is still delivered, then IDLE with `busy`=0 and no further `res_valid`.
- `rst_n` pulsed low during GATE → all outputs 0 immediately. After release with `run`=1, the first result is for the lowest enabled channel, 106 cycles later.
